chan_scan_mux: RTL and testbench
================================

Name: chan_scan_mux

Overview:
Parametrised N:1 channel multiplexer with an integrated select sequencer and a registered output. It replaces a fixed 4:1 mux driven by an external select counter. The block scans or selects one of NCH input channels of width W. It supports hold, free-running scan, masked scan that skips disabled channels, and direct select load. It is the front-end channel selector for sampling and debug-observe paths.

Parameters:
NCH, 4, number of input channels (>=2, need not be a power of two)
W, 1, data width per channel in bits
SELW, $clog2(NCH), select width (derived localparam, not overridable)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  reset, asynchronous, active-high
din  input  NCH*W  flattened channel inputs; channel k occupies din[k*W +: W]
mode  input  2  00 hold, 01 scan, 10 masked scan, 11 load
step_en  input  1  advance/load qualifier, sampled at clk
ld_sel  input  SELW  select value used in mode 11
ch_mask  input  NCH  channel enables for mode 10; bit k = channel k
sel  output  SELW  current select register
y  output  W  registered selected data
y_valid  output  1  y holds a sample taken after reset release
wrap  output  1  one-cycle pulse when the select wraps around

Behaviour:
- Reset (async, immediate, no clock needed): sel=0, y=0, y_valid=0, wrap=0. Reset asserted mid-scan aborts the scan. The first rising clk edge after reset deassertion restarts from channel 0.
- Data path, every clk edge: y <= din[sel*W +: W], using the sel value present before the edge. Latency: y reflects the channel selected during the previous cycle (1 cycle).
- y_valid: set to 1 on the first clk edge after reset release; stays 1 until the next reset.
- Select update occurs only on an edge where step_en=1. With step_en=0, sel holds in every mode and wrap=0.
- mode 00 (hold): sel unchanged, wrap=0.
- mode 01 (scan): sel <= (sel==NCH-1) ? 0 : sel+1. wrap=1 on the edge where sel goes NCH-1 -> 0. Never visits indices >= NCH.
- mode 10 (masked scan): sel <= the lowest-distance enabled index after sel, searching circularly (sel+1, sel+2, ..., NCH-1, 0, ..., sel).
  - wrap=1 if the found index <= current sel, i.e. the search passed index 0 or only the current channel is enabled.
  - ch_mask all zero: sel holds, wrap=0.
  - Search is combinational within one cycle; no multi-cycle walk.
- mode 11 (load): sel <= ld_sel if ld_sel < NCH. If ld_sel >= NCH, sel holds. wrap=0.
- A mode change takes effect on the same edge it is sampled. No pipeline flush is needed because y always uses the registered sel.
- wrap is registered; it is high for exactly one cycle per wrap event.
- sel out of range (>= NCH) is unreachable by construction. Data path default for any unreachable index is y <= 0, with no latch inference: full default assignment.
- din and ch_mask are sampled only at clk; no combinational path from inputs to outputs.

Test Plan:
- Async reset: mid-scan in mode 01 (sel=2), pulse reset for 3 ns between edges -> sel=0, y=0, y_valid=0, wrap=0 immediately. First post-release edge -> y_valid=1, y=din ch0.
- Scan, NCH=4, W=8, din={8'h44,8'h33,8'h22,8'h11}, mode=01, step_en=1 -> sel 0,1,2,3,0,... and y 11,22,33,44,11 (one cycle behind sel). wrap high only on the 3->0 edge.
- Non-power-of-two, NCH=5 -> sel 0,1,2,3,4,0. wrap on 4->0. sel never reaches 5-7.
- Masked scan, NCH=4, mask=4'b1010, start sel=0, mode=10 -> sel 1,3,1,3. wrap on each 3->1. Mask changed to 4'b0000 -> sel holds at its value, wrap=0. Mask=4'b0010 with sel=1 -> sel stays 1 with wrap=1 each step.
- Load, NCH=5, mode=11 -> ld_sel=2 with step_en=1 gives sel=2 next cycle and y=din ch2 the cycle after. ld_sel=7 gives sel unchanged.
- Hold/qualify: mode=00 with step_en=1 -> sel constant for 10 cycles. mode=01 with step_en toggling 1,0,1,0 -> sel advances only on step_en=1 edges.

Source files
------------

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N:1 channel mux with built-in select sequencer (hold/scan/masked scan/load) and registered output
module chan_scan_mux #(
  parameter int NCH = 4,
  parameter int W = 1,
  localparam int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*W-1:0]  din,
  input  logic [1:0]        mode,
  input  logic              step_en,
  input  logic [SELW-1:0]   ld_sel,
  input  logic [NCH-1:0]    ch_mask,
  output logic [SELW-1:0]   sel,
  output logic [W-1:0]      y,
  output logic              y_valid,
  output logic              wrap
);
  logic [SELW-1:0] scan_nxt;
  logic [SELW-1:0] mask_nxt;
  logic [SELW-1:0] sel_nxt;
  logic [W-1:0]    y_nxt;
  logic            mask_any;
  logic            load_ok;
  logic            wrap_nxt;
  assign scan_nxt = (sel == SELW'(NCH - 1)) ? '0 : sel + 1'b1;
  assign mask_any = |ch_mask;
  assign load_ok  = int'(ld_sel) < NCH;
  // circular search for the nearest enabled channel after sel; walking distances downward lets the closest win
  always_comb begin
    mask_nxt = sel;
    for (int d = NCH; d >= 1; d--)
      if (ch_mask[(int'(sel) + d) % NCH]) mask_nxt = SELW'((int'(sel) + d) % NCH);
  end
  // select and wrap decision for this edge; nothing moves without step_en
  always_comb begin
    sel_nxt  = !step_en                  ? sel      :
               mode == 2'b01             ? scan_nxt :
               mode == 2'b10             ? mask_nxt :
               (mode == 2'b11 && load_ok) ? ld_sel  : sel;
    wrap_nxt = step_en && ((mode == 2'b01 && sel == SELW'(NCH - 1)) ||
                           (mode == 2'b10 && mask_any && mask_nxt <= sel));
  end
  // data mux from the registered select; unreachable indices read as zero
  always_comb begin
    y_nxt = '0;
    for (int k = 0; k < NCH; k++)
      if (sel == SELW'(k)) y_nxt = din[k*W +: W];
  end
  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      sel     <= sel_nxt;
      y       <= y_nxt;
      y_valid <= 1'b1;
      wrap    <= wrap_nxt;
    end
  end
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: randomized and directed checks of 4- and 5-channel instances against a behavioural model
module tb_chan_scan_mux;
  logic        clk = 0;
  logic        reset = 1;
  logic [39:0] d5 = '0;
  logic [1:0]  mode = 2'b00;
  logic        step_en = 0;
  logic [2:0]  ld = '0;
  logic [4:0]  m5 = '0;
  logic [1:0]  sel4;
  logic [7:0]  y4;
  logic        yv4, wrap4;
  logic [2:0]  sel5;
  logic [7:0]  y5;
  logic        yv5, wrap5;
  int tests = 0;
  int fails = 0;
  int ms4, ms5;
  bit mw4, mw5, mv;
  logic [7:0] my4, my5;
  logic [25:0] obs;

  always #5 clk = ~clk;

  chan_scan_mux #(.NCH(4), .W(8)) dut4 (
    .clk(clk), .reset(reset), .din(d5[31:0]), .mode(mode), .step_en(step_en),
    .ld_sel(ld[1:0]), .ch_mask(m5[3:0]), .sel(sel4), .y(y4), .y_valid(yv4), .wrap(wrap4));

  chan_scan_mux #(.NCH(5), .W(8)) dut5 (
    .clk(clk), .reset(reset), .din(d5), .mode(mode), .step_en(step_en),
    .ld_sel(ld), .ch_mask(m5), .sel(sel5), .y(y5), .y_valid(yv5), .wrap(wrap5));

  assign obs = {sel4, y4, wrap4, yv4, sel5, y5, wrap5, yv5};

  function automatic logic [25:0] expv();
    return {2'(ms4), my4, mw4, mv, 3'(ms5), my5, mw5, mv};
  endfunction

  task automatic model_reset();
    ms4 = 0; ms5 = 0; mw4 = 0; mw5 = 0; mv = 0; my4 = '0; my5 = '0;
  endtask

  task automatic mstep(input int nch, input int s, input int l, output int ns, output bit w);
    bit done = 0;
    ns = s;
    w = 0;
    if (step_en) begin
      if (mode == 2'b01) begin
        ns = (s + 1) % nch;
        w = (ns == 0);
      end else if (mode == 2'b10) begin
        for (int d = 1; d <= nch; d++)
          if (!done && m5[(s + d) % nch]) begin
            ns = (s + d) % nch;
            w = (ns <= s);
            done = 1;
          end
      end else if (mode == 2'b11 && l < nch) ns = l;
    end
  endtask

  task automatic tick();
    int ns;
    bit w;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      my4 = d5[ms4*8 +: 8];
      my5 = d5[ms5*8 +: 8];
      mstep(4, ms4, int'(ld[1:0]), ns, w); ms4 = ns; mw4 = w;
      mstep(5, ms5, int'(ld), ns, w); ms5 = ns; mw5 = w;
      mv = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL reset_init got=%h exp=%h", obs, expv()); end
    d5 = 40'h55_44_33_22_11;
    tick();
    reset = 0;
    mode = 2'b01;
    step_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL reset_prescan got=%h exp=%h", obs, expv()); end
    end
    reset = 1;
    #1;
    model_reset();
    tests++;
    if (obs !== expv()) begin fails++; $display("FAIL reset_async got=%h exp=%h", obs, expv()); end
    #2 reset = 0;
    tick();
    tests++;
    if (obs !== expv() || y4 !== 8'h11 || yv4 !== 1'b1) begin fails++; $display("FAIL reset_release got=%h exp=%h", obs, expv()); end
  endtask

  task automatic test_scan();
    mode = 2'b11; ld = 0; step_en = 1;
    tick();
    mode = 2'b01;
    d5 = 40'h55_44_33_22_11;
    for (int i = 0; i < 12; i++) begin
      tick();
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL scan[%0d] got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_masked();
    mode = 2'b11; ld = 0; step_en = 1;
    tick();
    mode = 2'b10;
    m5 = 5'b01010;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL masked[%0d] got=%h exp=%h", i, obs, expv()); end
    end
    m5 = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== expv() || wrap4 !== 1'b0) begin fails++; $display("FAIL mask_zero[%0d] got=%h exp=%h", i, obs, expv()); end
    end
    mode = 2'b11; ld = 1;
    tick();
    mode = 2'b10;
    m5 = 5'b00010;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (obs !== expv() || sel4 !== 2'd1) begin fails++; $display("FAIL mask_self[%0d] got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_load();
    logic [2:0] lds [6] = '{3'd2, 3'd7, 3'd4, 3'd5, 3'd0, 3'd6};
    mode = 2'b11; step_en = 1;
    d5 = 40'hA5_A4_A3_A2_A1;
    foreach (lds[i]) begin
      ld = lds[i];
      tick();
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL load[%0d] got=%h exp=%h", i, obs, expv()); end
    end
    ld = 2;
    tick();
    tick();
    tests++;
    if (obs !== expv() || y5 !== 8'hA3) begin fails++; $display("FAIL load_data got=%h exp=%h", obs, expv()); end
  endtask

  task automatic test_hold();
    mode = 2'b00; step_en = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL hold[%0d] got=%h exp=%h", i, obs, expv()); end
    end
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      step_en = (i % 2 == 0);
      tick();
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL qualify[%0d] got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      mode = 2'($urandom_range(0, 3));
      step_en = ($urandom % 4) != 0;
      m5 = 5'($urandom);
      ld = 3'($urandom);
      if ($urandom % 8 == 0) d5 = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
      if ($urandom % 50 == 0) begin
        reset = 1;
        #1;
        model_reset();
        tests++;
        if (obs !== expv()) begin fails++; $display("FAIL rand_reset[%0d] got=%h exp=%h", i, obs, expv()); end
        #2 reset = 0;
      end
      tick();
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL rand[%0d] got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_masked();
    test_load();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
